// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Covers stall causes, the shadow entry layout and the boundary numbering.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      CAUSE_RUN      = 2'd0,
      CAUSE_LD_STALL = 2'd1,
      CAUSE_MEM_WAIT = 2'd2,
      CAUSE_BR_FLUSH = 2'd3
   } cause_t;

   // rd is stored zero-extended to this width, so REG_W must not exceed it.
   localparam int SH_RD_W = 8;

   typedef struct packed {
      logic               vld;
      logic [SH_RD_W-1:0] rd;
      logic               is_load;
   } shadow_t;

   localparam int B_IF_ID  = 0;
   localparam int B_ID_EX  = 1;
   localparam int B_EX_MEM = 2;

   function automatic int b_mem_wb(input int nstages);
      return nstages - 2;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// There is no handshake: every input is sampled every cycle, and every output is valid every cycle.
interface pipe_hazard_ctrl_if #(
   parameter int NSTAGES = 5,
   parameter int REG_W   = 5,
   parameter int CNT_W   = 32
);
   localparam int NB = NSTAGES - 1;

   logic             id_vld;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] id_rd;
   logic             id_is_load;
   logic             ex_take_br;
   logic             mem_busy;
   logic             clr_cnt;
   logic [NB-1:0]    st_en;
   logic [NB-1:0]    st_flush;
   logic [1:0]       st_cause;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_vld, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_is_load,
      output ex_take_br, mem_busy, clr_cnt,
      input  st_en, st_flush, st_cause, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_vld, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_is_load,
      input  ex_take_br, mem_busy, clr_cnt,
      output st_en, st_flush, st_cause, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// The clear takes priority over the increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-boundary enable/flush strobes for load-use, memory wait and taken branch.
// It tracks {vld, rd, is_load} for each boundary from ID/EX onward, which is enough to detect a load-use hazard.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NSTAGES = 5,
   parameter int REG_W   = 5,
   parameter int LD_WIN  = 1,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave io_ctrl
);

   localparam int NB       = NSTAGES - 1;
   localparam int B_MEM_WB = b_mem_wb(NSTAGES);

   shadow_t          r_shadow [1:NB-1];
   cause_t           r_cause;
   cause_t           w_cause;
   shadow_t          w_id_entry;
   logic [SH_RD_W-1:0] w_rs1;
   logic [SH_RD_W-1:0] w_rs2;
   logic             w_hit;
   logic [NB-1:0]    w_en;
   logic [NB-1:0]    w_flush;
   logic             w_stall_inc;
   logic             w_flush_inc;
   logic [CNT_W-1:0] w_stall_cnt;
   logic [CNT_W-1:0] w_flush_cnt;

   assign w_rs1              = SH_RD_W'(io_ctrl.id_rs1);
   assign w_rs2              = SH_RD_W'(io_ctrl.id_rs2);
   assign w_id_entry.vld     = io_ctrl.id_vld;
   assign w_id_entry.rd      = SH_RD_W'(io_ctrl.id_rd);
   assign w_id_entry.is_load = io_ctrl.id_is_load;

   // Only the first LD_WIN shadow stages hold loads whose data is not yet forwardable.
   always_comb begin
      w_hit = 1'b0;
      for (int k = 1; k < NB; k++) begin
         if ((k <= LD_WIN) && r_shadow[k].vld && r_shadow[k].is_load &&
             (r_shadow[k].rd != '0) &&
             ((io_ctrl.id_use_rs1 && (w_rs1 == r_shadow[k].rd)) ||
              (io_ctrl.id_use_rs2 && (w_rs2 == r_shadow[k].rd)))) begin
            w_hit = 1'b1;
         end
      end
      w_hit = w_hit & io_ctrl.id_vld;
   end

   always_comb begin
      if (io_ctrl.mem_busy) begin
         w_cause = CAUSE_MEM_WAIT;
      end else if (io_ctrl.ex_take_br) begin
         w_cause = CAUSE_BR_FLUSH;
      end else if (w_hit) begin
         w_cause = CAUSE_LD_STALL;
      end else begin
         w_cause = CAUSE_RUN;
      end
   end

   // A memory wait freezes every stage up to MEM, and MEM/WB receives a bubble.
   always_comb begin
      w_en    = '1;
      w_flush = '0;
      if (!rst) begin
         case (w_cause)
            CAUSE_MEM_WAIT: begin
               w_en              = '0;
               w_en[B_MEM_WB]    = 1'b1;
               w_flush[B_MEM_WB] = 1'b1;
            end
            CAUSE_BR_FLUSH: begin
               w_flush[B_IF_ID] = 1'b1;
               w_flush[B_ID_EX] = 1'b1;
            end
            CAUSE_LD_STALL: begin
               w_en[B_IF_ID]    = 1'b0;
               w_flush[B_ID_EX] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k < NB; k++) begin
            r_shadow[k] <= '0;
         end
      end else begin
         if (w_en[B_ID_EX]) begin
            r_shadow[1] <= w_flush[B_ID_EX] ? '0 : w_id_entry;
         end
         for (int k = 2; k < NB; k++) begin
            if (w_en[k]) begin
               r_shadow[k] <= w_flush[k] ? '0 : r_shadow[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cause <= CAUSE_RUN;
      end else begin
         r_cause <= w_cause;
      end
   end

   assign w_stall_inc = (w_cause == CAUSE_LD_STALL) || (w_cause == CAUSE_MEM_WAIT);
   assign w_flush_inc = (w_cause == CAUSE_BR_FLUSH);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_stall_inc),
      .i_clr (io_ctrl.clr_cnt),
      .o_cnt (w_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_flush_inc),
      .i_clr (io_ctrl.clr_cnt),
      .o_cnt (w_flush_cnt)
   );

   assign io_ctrl.st_en     = w_en;
   assign io_ctrl.st_flush  = w_flush;
   assign io_ctrl.st_cause  = r_cause;
   assign io_ctrl.stall_cnt = w_stall_cnt;
   assign io_ctrl.flush_cnt = w_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LD_WIN=1/CNT_W=32 and LD_WIN=2/CNT_W=4) share one stimulus stream.
// A pipeline-occupancy model predicts each cycle; a monitor pops and compares the predictions.
module tb_pipe_hazard_ctrl;

   localparam int EXP_W = 74;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [EXP_W-1:0] exp_q0[$];
   logic [EXP_W-1:0] exp_q1[$];

   // Model state: contents of ID/EX, EX/MEM and MEM/WB per instance (index 1..3), plus registered outputs.
   logic       mv [2][4];
   logic [4:0] mr [2][4];
   logic       ml [2][4];
   logic [1:0] m_cause [2];
   logic [31:0] m_stall [2];
   logic [31:0] m_fcnt  [2];
   int          win  [2];
   logic [31:0] cmax [2];

   pipe_hazard_ctrl_if #(.NSTAGES(5), .REG_W(5), .CNT_W(32)) if0 ();
   pipe_hazard_ctrl_if #(.NSTAGES(5), .REG_W(5), .CNT_W(4))  if1 ();

   pipe_hazard_ctrl #(.NSTAGES(5), .REG_W(5), .LD_WIN(1), .CNT_W(32)) u_dut0 (
      .clk     (clk),
      .rst     (rst),
      .io_ctrl (if0.slave)
   );

   pipe_hazard_ctrl #(.NSTAGES(5), .REG_W(5), .LD_WIN(2), .CNT_W(4)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .io_ctrl (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset(input int d);
      for (int k = 1; k < 4; k++) begin
         mv[d][k] = 1'b0;
         mr[d][k] = '0;
         ml[d][k] = 1'b0;
      end
      m_cause[d] = 2'd0;
      m_stall[d] = '0;
      m_fcnt[d]  = '0;
   endtask

   // Drive one cycle of inputs, predict both instances and advance the model past the next clock edge.
   task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                       input logic br, input logic busy, input logic clr, input logic rst_v);
      logic       hit;
      logic [1:0] cause;
      logic [3:0] e_en;
      logic [3:0] e_fl;
      @(negedge clk);
      rst = rst_v;
      if0.id_vld = v;    if1.id_vld = v;
      if0.id_rs1 = rs1;  if1.id_rs1 = rs1;
      if0.id_rs2 = rs2;  if1.id_rs2 = rs2;
      if0.id_use_rs1 = u1; if1.id_use_rs1 = u1;
      if0.id_use_rs2 = u2; if1.id_use_rs2 = u2;
      if0.id_rd = rd;    if1.id_rd = rd;
      if0.id_is_load = ld; if1.id_is_load = ld;
      if0.ex_take_br = br; if1.ex_take_br = br;
      if0.mem_busy = busy; if1.mem_busy = busy;
      if0.clr_cnt = clr; if1.clr_cnt = clr;
      for (int d = 0; d < 2; d++) begin
         if (rst_v) model_reset(d);
         hit = 1'b0;
         for (int k = 1; k <= win[d]; k++) begin
            if (v && mv[d][k] && ml[d][k] && (mr[d][k] != 0) &&
                ((u1 && rs1 == mr[d][k]) || (u2 && rs2 == mr[d][k]))) hit = 1'b1;
         end
         cause = busy ? 2'd2 : br ? 2'd3 : hit ? 2'd1 : 2'd0;
         if (rst_v) begin
            e_en = 4'b1111; e_fl = 4'b0000;
         end else begin
            case (cause)
               2'd2:    begin e_en = 4'b1000; e_fl = 4'b1000; end
               2'd3:    begin e_en = 4'b1111; e_fl = 4'b0011; end
               2'd1:    begin e_en = 4'b1110; e_fl = 4'b0010; end
               default: begin e_en = 4'b1111; e_fl = 4'b0000; end
            endcase
         end
         if (d == 0) exp_q0.push_back({e_en, e_fl, m_cause[d], m_stall[d], m_fcnt[d]});
         else        exp_q1.push_back({e_en, e_fl, m_cause[d], m_stall[d], m_fcnt[d]});
         if (!rst_v) begin
            m_cause[d] = cause;
            if (clr) m_stall[d] = '0;
            else if ((cause == 2'd1 || cause == 2'd2) && m_stall[d] != cmax[d]) m_stall[d]++;
            if (clr) m_fcnt[d] = '0;
            else if (cause == 2'd3 && m_fcnt[d] != cmax[d]) m_fcnt[d]++;
            if (cause == 2'd2) begin
               mv[d][3] = 1'b0; mr[d][3] = '0; ml[d][3] = 1'b0;
            end else begin
               mv[d][3] = mv[d][2]; mr[d][3] = mr[d][2]; ml[d][3] = ml[d][2];
               mv[d][2] = mv[d][1]; mr[d][2] = mr[d][1]; ml[d][2] = ml[d][1];
               if (cause == 2'd0) begin
                  mv[d][1] = v; mr[d][1] = rd; ml[d][1] = ld;
               end else begin
                  mv[d][1] = 1'b0; mr[d][1] = '0; ml[d][1] = 1'b0;
               end
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input logic clr);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, clr, 0);
   endtask

   // Monitor: outputs are valid every cycle, so one prediction is consumed per instance per cycle.
   initial begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] a;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            a = {if0.st_en, if0.st_flush, if0.st_cause, if0.stall_cnt, if0.flush_cnt};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL dut0 @%0t: got en=%b fl=%b cause=%0d stall=%0d fcnt=%0d want en=%b fl=%b cause=%0d stall=%0d fcnt=%0d",
                        $time, a[73:70], a[69:66], a[65:64], a[63:32], a[31:0],
                        e[73:70], e[69:66], e[65:64], e[63:32], e[31:0]);
            end
         end
         if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            a = {if1.st_en, if1.st_flush, if1.st_cause, 28'd0, if1.stall_cnt, 28'd0, if1.flush_cnt};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL dut1 @%0t: got en=%b fl=%b cause=%0d stall=%0d fcnt=%0d want en=%b fl=%b cause=%0d stall=%0d fcnt=%0d",
                        $time, a[73:70], a[69:66], a[65:64], a[63:32], a[31:0],
                        e[73:70], e[69:66], e[65:64], e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      win[0] = 1;  win[1] = 2;
      cmax[0] = 32'hFFFF_FFFF;  cmax[1] = 32'd15;
      model_reset(0);
      model_reset(1);
      rst = 1'b1;
      if0.id_vld = 0; if0.id_rs1 = 0; if0.id_rs2 = 0; if0.id_use_rs1 = 0; if0.id_use_rs2 = 0;
      if0.id_rd = 0; if0.id_is_load = 0; if0.ex_take_br = 0; if0.mem_busy = 0; if0.clr_cnt = 0;
      if1.id_vld = 0; if1.id_rs1 = 0; if1.id_rs2 = 0; if1.id_use_rs1 = 0; if1.id_use_rs2 = 0;
      if1.id_rd = 0; if1.id_is_load = 0; if1.ex_take_br = 0; if1.mem_busy = 0; if1.clr_cnt = 0;

      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("reset_en", 64'(if0.st_en), 64'hF);
      chk("reset_fl", 64'(if0.st_flush), 64'h0);
      idle(1, 0);
      chk("reset_cause", 64'(if0.st_cause), 64'd0);
      chk("reset_stall", 64'(if0.stall_cnt), 64'd0);

      // lw x5 ; add x6,x5,x1
      idle(1, 1);
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0);
      chk("ld_use_en", 64'(if0.st_en), 64'b1110);
      chk("ld_use_fl", 64'(if0.st_flush), 64'b0010);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0);
      chk("ld_use_release", 64'(if0.st_en), 64'b1111);
      chk("ld_use_cnt", 64'(if0.stall_cnt), 64'd1);
      idle(3, 0);

      // lw x5 ; nop ; add x7,x5,x5 (only the LD_WIN=2 instance stalls), then lw x0 ; add x7,x0,x0
      idle(1, 1);
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 5, 5, 1, 1, 7, 0, 0, 0, 0, 0);
      chk("win2_stall", 64'(if1.st_en), 64'b1110);
      chk("win1_nostall", 64'(if0.st_en), 64'b1111);
      step(1, 5, 5, 1, 1, 7, 0, 0, 0, 0, 0);
      chk("win2_cnt", 64'(if1.stall_cnt), 64'd1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0);
      chk("x0_nostall", 64'(if1.st_en), 64'b1111);
      idle(3, 0);

      // taken branch together with a load-use hit
      idle(1, 1);
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 0, 1, 0, 0, 0);
      chk("br_en", 64'(if0.st_en), 64'b1111);
      chk("br_fl", 64'(if0.st_flush), 64'b0011);
      idle(1, 0);
      chk("br_cause", 64'(if0.st_cause), 64'd3);
      chk("br_fcnt", 64'(if0.flush_cnt), 64'd1);
      idle(3, 0);

      // three memory-wait cycles holding a taken branch, then the flush
      idle(1, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
         chk("memw_en", 64'(if0.st_en), 64'b1000);
         chk("memw_fl", 64'(if0.st_flush), 64'b1000);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("memw_br_fl", 64'(if0.st_flush), 64'b0011);
      idle(1, 0);
      chk("memw_stall", 64'(if0.stall_cnt), 64'd3);
      chk("memw_fcnt", 64'(if0.flush_cnt), 64'd1);

      // saturation of the 4-bit counter, then clear winning over increment
      idle(1, 1);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(1, 0);
      chk("sat_cnt4", 64'(if1.stall_cnt), 64'd15);
      chk("sat_cnt32", 64'(if0.stall_cnt), 64'd20);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle(1, 0);
      chk("clr_wins", 64'(if1.stall_cnt), 64'd0);

      // reset during a load-use stall
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 1);
      chk("rst_mid_en", 64'(if1.st_en), 64'b1111);
      chk("rst_mid_cnt", 64'(if1.stall_cnt), 64'd0);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0);
      chk("rst_after_en", 64'(if1.st_en), 64'b1111);
      chk("rst_after_cause", 64'(if1.st_cause), 64'd0);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
      end

      @(negedge clk);
      #4;
      total++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d/%0d left want 0/0", exp_q0.size(), exp_q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
